// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-256 block decryption controller: one 128-bit state register, one
// inverse round per clock, round keys fetched by index from the expanded-key store.
module aes_dec_iter_ctrl #(
   parameter int ROUNDS = 14,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             keyReady,
   input  logic             inValid,
   output logic             inReady,
   input  logic [127:0]     inData,
   output logic [IDX_W-1:0] keyIdx,
   input  logic [127:0]     roundKey,
   output logic             outValid,
   input  logic             outReady,
   output logic [127:0]     outData,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, FIRST, ROUND, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ROUNDS);
   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(ROUNDS - 1);
   localparam logic [IDX_W-1:0] CNT_START = IDX_W'(ROUNDS - 2);

   state_t             state, state_nxt;
   logic [127:0]       state_reg;
   logic [127:0]       out_q;
   logic               out_valid_q;
   logic [IDX_W-1:0]   cnt;
   logic [127:0]       sub_in;
   logic [127:0]       round_out;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] y;
      y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction

   // Byte i of the block sits at bits [127-8i -: 8]; row r, column c is byte r+4c.
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   // FIRST and ROUND share one S-box bank; only ROUND inserts InvMixColumns in front.
   assign sub_in    = (state == ROUND) ? inv_mix_columns(state_reg) : state_reg;
   assign round_out = inv_shift_sub(sub_in) ^ roundKey;

   assign inReady  = (state == IDLE) && keyReady;
   assign busy     = (state == FIRST) || (state == ROUND);
   assign outValid = out_valid_q;
   assign outData  = out_q;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      keyIdx    = LAST_IDX;
      case (state)
         IDLE:  if (inValid && inReady) state_nxt = FIRST;
         FIRST: begin
            keyIdx    = FIRST_IDX;
            state_nxt = ROUND;
         end
         ROUND: begin
            keyIdx = cnt;
            if (cnt == '0) state_nxt = DONE;
         end
         DONE:  if (outReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      if (rst) begin
         state       <= IDLE;
         state_reg   <= '0;
         cnt         <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE:  if (inValid && inReady) state_reg <= inData ^ roundKey;
            FIRST: begin
               state_reg <= round_out;
               cnt       <= CNT_START;
            end
            ROUND: begin
               state_reg <= round_out;
               if (cnt == '0) begin
                  out_q       <= round_out;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt <= cnt - IDX_W'(1);
               end
            end
            DONE:  if (outReady) out_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Bench for aes_dec_iter_ctrl: supplies round keys by index from its own key expansion
// and checks plaintexts through a scoreboard filled on each accepted ciphertext.
module tb_aes_dec_iter_ctrl;

   localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT1  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] ZCT  = 128'hdc95c078a2408989ad48a21492842087;

   logic         clk = 1'b0;
   logic         rst;
   logic         keyReady;
   logic         inValid;
   logic         inReady;
   logic [127:0] inData;
   logic [3:0]   keyIdx;
   logic [127:0] roundKey;
   logic         outValid;
   logic         outReady;
   logic [127:0] outData;
   logic         busy;

   logic [7:0]   sbox [256];
   logic [127:0] rk [16];
   logic [127:0] cur_exp;
   logic [127:0] sb [$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           acc_cyc_mon = 0;
   logic         ov_q = 1'b0;

   aes_dec_iter_ctrl #(.ROUNDS(14), .IDX_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .keyReady (keyReady),
      .inValid  (inValid),
      .inReady  (inReady),
      .inData   (inData),
      .keyIdx   (keyIdx),
      .roundKey (roundKey),
      .outValid (outValid),
      .outReady (outReady),
      .outData  (outData),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign roundKey = rk[keyIdx];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (forward cipher + key expansion) ----------------
   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      repeat (8) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = {1'b0, bb[7:1]};
      end
      return mul_ret(p);
   endfunction

   function automatic logic [7:0] mul_ret(input logic [7:0] p);
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, r1, r2, r3, r4;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
         sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
      end
   endtask

   task automatic expand_key(input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = mul(rcon, 8'h02);
         end else if (i % 8 == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      rk[15] = '0;
   endtask

   function automatic logic [127:0] enc_sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = sbox[s[127-8*(r+4*((c+r)%4)) -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] enc_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = s[127-8*(k+4*c) -: 8];
         o[127-32*c -: 8] = mul(a[0], 8'h02) ^ mul(a[1], 8'h03) ^ a[2] ^ a[3];
         o[119-32*c -: 8] = a[0] ^ mul(a[1], 8'h02) ^ mul(a[2], 8'h03) ^ a[3];
         o[111-32*c -: 8] = a[0] ^ a[1] ^ mul(a[2], 8'h02) ^ mul(a[3], 8'h03);
         o[103-32*c -: 8] = mul(a[0], 8'h03) ^ a[1] ^ a[2] ^ mul(a[3], 8'h02);
      end
      return o;
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ rk[0];
      for (int r = 1; r < 14; r++) s = enc_mix(enc_sub_shift(s)) ^ rk[r];
      return enc_sub_shift(s) ^ rk[14];
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (inValid && inReady) begin
            sb.push_back(cur_exp);
            acc_cyc_mon <= cyc;
         end
         if (outValid && !ov_q) check("latency", 128'(cyc - acc_cyc_mon), 128'(15));
         if (outValid && outReady) begin
            check("output_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) check("out_data", outData, sb.pop_front());
         end
      end
      ov_q <= outValid;
   end

   // ---------------- stimulus helpers ----------------
   task automatic offer(input logic [127:0] ct, input logic [127:0] exp,
                        output int acc, output int idle);
      inData  = ct;
      cur_exp = exp;
      inValid = 1'b1;
      idle    = 0;
      acc     = -1;
      for (int n = 0; n < 60 && acc < 0; n++) begin
         if (!busy) idle++;
         if (inReady) begin
            tick();
            acc = cyc;
         end else begin
            tick();
         end
      end
      inValid = 1'b0;
      check("accept", 128'(acc >= 0), 128'(1));
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      while (!outValid && n < 40) begin
         tick();
         n++;
      end
      check("out_valid_seen", 128'(outValid), 128'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc1, acc2, idle1, idle2;
      logic [127:0] pt2;

      rst = 1'b1; keyReady = 1'b1; inValid = 1'b0; outReady = 1'b0;
      inData = '0; cur_exp = '0;
      build_sbox();
      expand_key(KEY1);

      // Reset state
      tick(); tick();
      check("rst_out_valid", 128'(outValid), 128'(0));
      check("rst_out_data", outData, 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_key_idx", 128'(keyIdx), 128'(14));
      check("rst_in_ready", 128'(inReady), 128'(1));
      rst = 1'b0;

      // FIPS-197 C.3 vector with round-key index sequence
      outReady = 1'b1;
      inData = CT1; cur_exp = PT1; inValid = 1'b1;
      check("idle_key_idx", 128'(keyIdx), 128'(14));
      tick();
      inValid = 1'b0;
      check("first_busy", 128'(busy), 128'(1));
      check("first_key_idx", 128'(keyIdx), 128'(13));
      for (int i = 12; i >= 0; i--) begin
         tick();
         check("round_key_idx", 128'(keyIdx), 128'(i));
      end
      tick();
      check("done_out_valid", 128'(outValid), 128'(1));
      check("done_out_data", outData, PT1);
      check("done_busy", 128'(busy), 128'(0));
      check("done_key_idx", 128'(keyIdx), 128'(14));
      check("done_in_ready", 128'(inReady), 128'(0));
      tick();
      check("one_cycle_valid", 128'(outValid), 128'(0));
      check("idle_in_ready", 128'(inReady), 128'(1));

      // Backpressure: output holds, no new accept while DONE
      outReady = 1'b0;
      offer(CT1, PT1, acc1, idle1);
      wait_out();
      inData = ZCT; cur_exp = '0; inValid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         check("hold_valid", 128'(outValid), 128'(1));
         check("hold_data", outData, PT1);
         check("hold_in_ready", 128'(inReady), 128'(0));
         tick();
      end
      inValid = 1'b0; outReady = 1'b1;
      check("hold_in_ready_last", 128'(inReady), 128'(0));
      tick();
      check("bp_released_valid", 128'(outValid), 128'(0));
      check("bp_released_in_ready", 128'(inReady), 128'(1));

      // Back-to-back blocks with outReady held high
      pt2 = {$urandom, $urandom, $urandom, $urandom};
      offer(CT1, PT1, acc1, idle1);
      offer(encrypt(pt2), pt2, acc2, idle2);
      check("accept_spacing", 128'(acc2 - acc1), 128'(16));
      check("busy_low_cycles", 128'(idle2), 128'(2));
      wait_out();
      tick();

      // Key gating, then keyReady dropped mid-block
      keyReady = 1'b0;
      inData = CT1; cur_exp = PT1; inValid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("gated_in_ready", 128'(inReady), 128'(0));
         check("gated_busy", 128'(busy), 128'(0));
      end
      keyReady = 1'b1;
      #1;
      check("ungated_in_ready", 128'(inReady), 128'(1));
      tick();
      inValid = 1'b0;
      check("ungated_busy", 128'(busy), 128'(1));
      keyReady = 1'b0;
      repeat (5) tick();
      check("no_stall_busy", 128'(busy), 128'(1));
      keyReady = 1'b1;
      wait_out();
      tick();

      // Reset during ROUND discards the block
      offer(CT1, PT1, acc1, idle1);
      repeat (7) tick();
      rst = 1'b1;
      sb.delete();
      tick();
      rst = 1'b0;
      check("mid_rst_out_valid", 128'(outValid), 128'(0));
      check("mid_rst_out_data", outData, 128'(0));
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_key_idx", 128'(keyIdx), 128'(14));
      repeat (20) tick();
      check("mid_rst_no_output", 128'(outValid), 128'(0));
      offer(CT1, PT1, acc1, idle1);
      wait_out();
      tick();

      // All-zero key and plaintext
      expand_key(256'h0);
      offer(ZCT, 128'h0, acc1, idle1);
      wait_out();
      tick();
      tick();

      check("scoreboard_empty", 128'(sb.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
